// File: rtl/rf_bank.sv
// 32-entry register file storage with two registered read ports (write-first bypass)
// and one-hot write-select re-encoding with malformed-select detection.
module rf_bank #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      we_onehot,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rvalid,
    output logic [4:0]       wr_idx,
    output logic             wr_done,
    output logic             wr_err
);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [WIDTH-1:0] regs [32];

    logic [31:0]      extra_bits;
    logic             sel_multi;
    logic             sel_valid;
    logic [4:0]       sel_idx;
    logic [WIDTH-1:0] rv1;
    logic [WIDTH-1:0] rv2;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign extra_bits = we_onehot & (we_onehot - 32'd1);
    assign sel_multi  = |extra_bits;
    assign sel_valid  = (|we_onehot) && !sel_multi;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (we_onehot[i]) begin
                sel_idx = sel_idx | 5'(i);
            end
        end
    end

    always_comb begin
        rv1 = regs[ra1];
        rv2 = regs[ra2];
        if (sel_valid && sel_idx == ra1) begin
            rv1 = wdata;
        end
        if (sel_valid && sel_idx == ra2) begin
            rv2 = wdata;
        end
        if (ra1 == 5'd0) begin
            rv1 = '0;
        end
        if (ra2 == 5'd0) begin
            rv2 = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            rd1     <= '0;
            rd2     <= '0;
            rvalid  <= 1'b0;
            wr_idx  <= '0;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            if (sel_valid && sel_idx != 5'd0) begin
                regs[sel_idx] <= wdata;
            end
            wr_done <= sel_valid;
            wr_err  <= sel_multi;
            if (sel_valid) begin
                wr_idx <= sel_idx;
            end
            rvalid <= re;
            if (re) begin
                rd1 <= rv1;
                rd2 <= rv2;
            end
        end
    end

endmodule

// File: doc/rf_bank.md
# rf_bank

Storage and read side of the 32 x 32-bit register file. It accepts the one-hot write-select vector produced by the 5-to-32 write decoder together with write data, and stores the word in the addressed register. It serves two registered read ports with write-first bypass. It also re-encodes the one-hot select into a 5-bit index, so the pipeline sees which register was written and is told when a select vector is malformed.

## Interface
- WIDTH, 32, data width of each register (register count fixed at 32, index width fixed at 5)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we_onehot  in  32  write select from the decoder; bit i selects register i; all-zero = no write
- wdata  in  WIDTH  write data
- re  in  1  read request; both ports are sampled when high
- ra1  in  5  read address, port 1
- ra2  in  5  read address, port 2
- rd1  out  WIDTH  registered read data, port 1
- rd2  out  WIDTH  registered read data, port 2
- rvalid  out  1  high the cycle after re was sampled high
- wr_idx  out  5  encoded index of the last accepted write
- wr_done  out  1  one-cycle pulse marking an accepted write (including a write to register 0)
- wr_err  out  1  one-cycle pulse marking a malformed (multi-hot) select vector

## Operation
- Classify we_onehot at each rising edge:
  - Zero bits set: idle.
  - Exactly one bit set: valid write.
  - Two or more bits set: error.
- Valid write to bit i, i != 0: regs[i] <= wdata.
- Valid write to bit 0: register 0 is not written; it is hardwired to 0 and always reads 0.
- Error: no register is modified.
- Encoder: for a valid write, wr_idx <= i and wr_done <= 1. Otherwise wr_done <= 0 and wr_idx holds its value.
- Error pulse: wr_err <= 1 for exactly the cycle after a multi-hot vector; 0 otherwise.
- Read with re = 1 at an edge: rd1 <= value(ra1), rd2 <= value(ra2), rvalid <= 1.
- value(a) is defined as:
  - 0 if a == 0;
  - wdata if the same edge carries a valid write to a (write-first bypass);
  - regs[a] otherwise.
- Read with re = 0: rd1 and rd2 hold; rvalid <= 0.
- Both ports may address the same register; both return the same value.
- State: the register array, the output registers and the single-bit flags. There is no multi-cycle FSM; each edge is independent.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible through the array from a read sampled at edge N+1. The bypass makes it visible to a read sampled at edge N.
- Read latency: 1 cycle. Address at edge N gives rd at edge N plus clock-to-q, with rvalid high for cycle N..N+1.
- Encoder flags (wr_idx, wr_done, wr_err) update at the same edge as the write they describe.
- Reset (rst_n low, asynchronous, any time including mid-write or mid-read):
  - all regs = 0, rd1 = rd2 = 0, rvalid = 0, wr_idx = 0, wr_done = 0, wr_err = 0;
  - a write coincident with reset assertion is lost.
- Reset release: the first edge with rst_n high behaves normally. No warm-up cycle.
- Simultaneous write and read of different registers: the read returns the old value of its own register; the write is unaffected.
- Multi-hot select with a read of any selected register: the read returns the stored value (no bypass).
- No wrap-around or overflow conditions exist. Addresses are full 5-bit, so every ra is legal.

## Test plan
- Reset: assert rst_n = 0 mid-stream after arbitrary writes -> all outputs 0 immediately; after release, reads of registers 1..31 return 0.
- Basic write and read:
  - we_onehot = 32'h0000_0020, wdata = 32'hDEAD_BEEF at edge N -> wr_done = 1, wr_idx = 5 after N;
  - re = 1, ra1 = 5, ra2 = 0 at edge N+1 -> rd1 = 32'hDEAD_BEEF, rd2 = 0, rvalid = 1.
- Register 0: we_onehot = 32'h0000_0001, wdata = 32'hFFFF_FFFF -> wr_done = 1, wr_idx = 0; next read with ra1 = 0 -> rd1 = 0.
- Bypass:
  - in the same cycle, we_onehot = 32'h8000_0000, wdata = 32'h1234_5678, re = 1, ra1 = ra2 = 31 -> rd1 = rd2 = 32'h1234_5678 after the edge;
  - in the same cycle, ra2 = 30 -> rd2 = prior regs[30].
- Malformed select: we_onehot = 32'h0000_0030, wdata = 32'hA5A5_A5A5 -> wr_err = 1 for exactly one cycle, wr_done = 0, wr_idx unchanged; subsequent reads of registers 4 and 5 return their previous contents.
- Hold and valid: re = 1 then re = 0 for 3 cycles while ra1 changes -> rvalid = 1 then 0, and rd1 holds the first value throughout.
